// File: rtl/fp_mac_sequencer.sv
// Drives one FP32 MAC PE through a LEN-pair dot-product job: clear, stream, drain, capture.
// Optional ZERO_SKIP_EN: pairs with a +/-0.0 operand are consumed without pulsing mac_en.
module fp_mac_sequencer #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [31:0]      mac_acc
);

  localparam int unsigned CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      mac_a_q, mac_a_d;
  logic [31:0]      mac_b_q, mac_b_d;
  logic             mac_en_q, mac_en_d;
  logic             done_q, done_d;
  logic [31:0]      result_q, result_d;
  logic             hs;
  logic             pair_live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      count_q  <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
      mac_en_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      mac_a_q  <= mac_a_d;
      mac_b_q  <= mac_b_d;
      mac_en_q <= mac_en_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

`ifdef ZERO_SKIP_EN
  assign pair_live = (in_a[30:0] != '0) && (in_b[30:0] != '0);
`else
  assign pair_live = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    count_d  = count_q;
    mac_a_d  = mac_a_q;
    mac_b_d  = mac_b_q;
    mac_en_d = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    in_ready = 1'b0;
    mac_clr  = 1'b0;
    hs       = 1'b0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // done_q high means we are in the done-pulse cycle; a start there is dropped.
        if (start && !done_q) begin
          rem_d   = len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clr = 1'b1;
        state_d = (rem_q != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        in_ready = (rem_q != '0);
        hs       = in_valid && in_ready;
        if (hs) begin
          mac_a_d  = in_a;
          mac_b_d  = in_b;
          mac_en_d = pair_live;
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
            count_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == CNT_W'(MAC_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        result_d = mac_acc;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done   = done_q;
  assign result = result_q;
  assign mac_a  = mac_a_q;
  assign mac_b  = mac_b_q;
  assign mac_en = mac_en_q;

endmodule
